// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter calculation path.
// Holds the scheduler state/sub-phase encodings, the percent scale and the
// saturated width of the frequency result.
package freq_meter_pkg;

    // Top-level scheduler states: one per quotient, bracketed by IDLE/DONE
    typedef enum logic [2:0] {
        IDLE,
        FREQ,
        DUTY,
        HT,
        LT,
        DONE
    } calc_state_t;

    // Sub-phases inside each quotient state
    typedef enum logic [1:0] {
        SETUP,
        RUN,
        CAPTURE
    } calc_phase_t;

    localparam int PCT_SCALE = 100;
    localparam int FREQ_W    = 34;

    // Largest representable frequency; larger quotients clamp to this
    localparam logic [FREQ_W-1:0] FREQ_SAT = {FREQ_W{1'b1}};

    // Quotient order: FREQ -> DUTY -> HT -> LT -> DONE
    function automatic calc_state_t next_op(input calc_state_t cur);
        calc_state_t nxt;
        nxt = DONE;
        case (cur)
            FREQ:    nxt = DUTY;
            DUTY:    nxt = HT;
            HT:      nxt = LT;
            default: nxt = DONE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/freq_calc_sched_seq_div.sv
// seq_div: iterative restoring divider, one quotient bit per cycle, MSB first.
// A div_start loads the operands; exactly DIV_W iterations follow with no
// early exit. done is high during the final iteration, so the quotient is
// complete from the following cycle. A zero divisor still runs the full
// sequence but the quotient reads as zero and div0 is flagged.
module seq_div #(
    parameter int DIV_W = 80,
    parameter int DVS_W = 49
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             div_start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient,
    output logic             div0
);

    localparam int ITER_W = $clog2(DIV_W + 1);

    logic [DIV_W-1:0]  work_q;
    logic [DVS_W-1:0]  rem_q;
    logic [DVS_W-1:0]  dvs_q;
    logic [ITER_W-1:0] iter_q;
    logic              zero_q;

    logic [DVS_W:0]    trial;
    logic [DVS_W-1:0]  diff;
    logic              fits;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        trial = {rem_q, work_q[DIV_W-1]};
        fits  = (trial >= {1'b0, dvs_q});
        diff  = trial[DVS_W-1:0] - dvs_q;
    end

    // Operand load on start, then one restoring step per cycle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            work_q <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            zero_q <= 1'b0;
        end else if (div_start) begin
            work_q <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
            iter_q <= ITER_W'(DIV_W);
            zero_q <= (divisor == '0);
        end else if (iter_q != '0) begin
            rem_q  <= fits ? diff : trial[DVS_W-1:0];
            work_q <= {work_q[DIV_W-2:0], fits};
            iter_q <= iter_q - ITER_W'(1);
        end
    end

    assign done     = (iter_q == ITER_W'(1));
    assign quotient = zero_q ? '0 : work_q;
    assign div0     = zero_q;

endmodule

// File: rtl/freq_calc_sched.sv
// freq_calc_sched: sequential calculation scheduler for the equal-precision
// frequency meter. A calc_start latches the four gate counters, then one
// shared restoring divider computes freq, duty, high_time and low_time in
// turn. Latency from an accepted calc_start to valid is fixed at
// 4*(DIV_W+2)+1 cycles, zero divisors included.
// Build option: define FREQ_CALC_ROUND_EN to add floor(divisor/2) to every
// dividend, giving round-half-up quotients (saturation applied afterwards).
module freq_calc_sched
    import freq_meter_pkg::*;
#(
    parameter int CLK_STAND_FREQ = 100_000_000,
    parameter int CNT_W          = 48,
    parameter int DIV_W          = 80
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              calc_start,
    input  logic [CNT_W-1:0]  cnt_clk_test,
    input  logic [CNT_W-1:0]  cnt_clk_stand,
    input  logic [CNT_W-1:0]  cnt_high,
    input  logic [CNT_W-1:0]  cnt_low,
    output logic              busy,
    output logic              valid,
    output logic              overrun,
    output logic              err_div0,
    output logic [FREQ_W-1:0] freq,
    output logic [7:0]        duty,
    output logic [63:0]       high_time,
    output logic [63:0]       low_time
);

    localparam int DVS_W = CNT_W + 1;

    calc_state_t       state_q, state_nxt;
    calc_phase_t       phase_q, phase_nxt;

    logic [CNT_W-1:0]  test_q, stand_q, high_q, low_q;
    logic [FREQ_W-1:0] freq_int;
    logic [7:0]        duty_int;
    logic [63:0]       ht_int;

    logic              div_start;
    logic [DIV_W-1:0]  op_dividend;
    logic [DVS_W-1:0]  op_divisor;
    logic              div_done;
    logic [DIV_W-1:0]  div_quotient;
    logic              div_div0;

    // Scheduler next-state: walk each op through SETUP/RUN/CAPTURE
    always_comb begin
        state_nxt = state_q;
        phase_nxt = phase_q;
        div_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (calc_start) begin
                    state_nxt = FREQ;
                    phase_nxt = SETUP;
                end
            end
            FREQ, DUTY, HT, LT: begin
                unique case (phase_q)
                    SETUP: begin
                        div_start = 1'b1;
                        phase_nxt = RUN;
                    end
                    RUN: begin
                        if (div_done) begin
                            phase_nxt = CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        phase_nxt = SETUP;
                        state_nxt = next_op(state_q);
                    end
                    default: phase_nxt = SETUP;
                endcase
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand formation for the divider, selected by the current op
    always_comb begin
        op_dividend = '0;
        op_divisor  = '0;
        unique case (state_q)
            FREQ: begin
                op_dividend = DIV_W'(CLK_STAND_FREQ) * DIV_W'(test_q);
                op_divisor  = DVS_W'(stand_q);
            end
            DUTY: begin
                op_dividend = DIV_W'(high_q) * DIV_W'(PCT_SCALE);
                op_divisor  = DVS_W'(high_q) + DVS_W'(low_q);
            end
            HT: begin
                op_dividend = DIV_W'(duty_int) * DIV_W'(freq_int);
                op_divisor  = DVS_W'(PCT_SCALE);
            end
            LT: begin
                op_dividend = DIV_W'(8'(PCT_SCALE) - duty_int) * DIV_W'(freq_int);
                op_divisor  = DVS_W'(PCT_SCALE);
            end
            default: begin
                op_dividend = '0;
                op_divisor  = '0;
            end
        endcase
`ifdef FREQ_CALC_ROUND_EN
        op_dividend = op_dividend + DIV_W'(op_divisor >> 1);
`else
        op_dividend = op_dividend;
`endif
    end

    // State and sub-phase registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            phase_q <= SETUP;
        end else begin
            state_q <= state_nxt;
            phase_q <= phase_nxt;
        end
    end

    // Counter capture, per-op result capture and publication of outputs
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            test_q    <= '0;
            stand_q   <= '0;
            high_q    <= '0;
            low_q     <= '0;
            freq_int  <= '0;
            duty_int  <= '0;
            ht_int    <= '0;
            err_div0  <= 1'b0;
            freq      <= '0;
            duty      <= '0;
            high_time <= '0;
            low_time  <= '0;
        end else if (state_q == IDLE) begin
            if (calc_start) begin
                test_q   <= cnt_clk_test;
                stand_q  <= cnt_clk_stand;
                high_q   <= cnt_high;
                low_q    <= cnt_low;
                err_div0 <= 1'b0;
            end
        end else if (phase_q == CAPTURE) begin
            err_div0 <= err_div0 | div_div0;
            unique case (state_q)
                FREQ: begin
                    freq_int <= (div_quotient > DIV_W'(FREQ_SAT)) ?
                                FREQ_SAT : div_quotient[FREQ_W-1:0];
                end
                DUTY: begin
                    duty_int <= (div_quotient > DIV_W'(PCT_SCALE)) ?
                                8'(PCT_SCALE) : div_quotient[7:0];
                end
                HT: begin
                    ht_int <= div_quotient[63:0];
                end
                LT: begin
                    // Publish on entry to DONE so results are present with valid
                    freq      <= freq_int;
                    duty      <= duty_int;
                    high_time <= ht_int;
                    low_time  <= div_quotient[63:0];
                end
                default: begin
                    ht_int <= ht_int;
                end
            endcase
        end
    end

    seq_div #(
        .DIV_W (DIV_W),
        .DVS_W (DVS_W)
    ) u_seq_div (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .div_start (div_start),
        .dividend  (op_dividend),
        .divisor   (op_divisor),
        .done      (div_done),
        .quotient  (div_quotient),
        .div0      (div_div0)
    );

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign valid   = (state_q == DONE);
    assign overrun = calc_start && (state_q != IDLE);

endmodule

// File: tb/tb_freq_calc_sched.sv
// Testbench for freq_calc_sched: directed and randomized calculations are
// queued with their expected results from an arithmetic reference model;
// a monitor pops and compares whenever valid is presented.
module tb_freq_calc_sched;

    localparam int DIV_W   = 80;
    localparam int LATENCY = 4 * (DIV_W + 2) + 1;

`ifdef FREQ_CALC_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    typedef struct {
        logic [33:0] freq;
        logic [7:0]  duty;
        logic [63:0] ht;
        logic [63:0] lt;
        logic        err;
        int          cyc;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        calc_start;
    logic [47:0] cnt_clk_test, cnt_clk_stand, cnt_high, cnt_low;
    logic        busy, valid, overrun, err_div0;
    logic [33:0] freq;
    logic [7:0]  duty;
    logic [63:0] high_time, low_time;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   vcount = 0;

    freq_calc_sched dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .calc_start    (calc_start),
        .cnt_clk_test  (cnt_clk_test),
        .cnt_clk_stand (cnt_clk_stand),
        .cnt_high      (cnt_high),
        .cnt_low       (cnt_low),
        .busy          (busy),
        .valid         (valid),
        .overrun       (overrun),
        .err_div0      (err_div0),
        .freq          (freq),
        .duty          (duty),
        .high_time     (high_time),
        .low_time      (low_time)
    );

    // Free-running clock and cycle counter
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the meter's formulas in plain wide arithmetic
    function automatic exp_t model(input logic [47:0] t, input logic [47:0] s,
                                   input logic [47:0] h, input logic [47:0] l);
        exp_t        e;
        logic [127:0] num, den, q, f, d, rnd;
        e.err = 1'b0;
        e.cyc = 0;
        if (s == 48'd0) begin
            f     = 128'd0;
            e.err = 1'b1;
        end else begin
            den = 128'(s);
            num = 128'd100_000_000 * 128'(t) + (ROUND ? den / 128'd2 : 128'd0);
            q   = num / den;
            f   = (q > 128'h3_FFFF_FFFF) ? 128'h3_FFFF_FFFF : q;
        end
        den = 128'(h) + 128'(l);
        if (den == 128'd0) begin
            d     = 128'd0;
            e.err = 1'b1;
        end else begin
            q = (128'(h) * 128'd100 + (ROUND ? den / 128'd2 : 128'd0)) / den;
            d = (q > 128'd100) ? 128'd100 : q;
        end
        rnd    = ROUND ? 128'd50 : 128'd0;
        e.freq = f[33:0];
        e.duty = d[7:0];
        e.ht   = 64'((d * f + rnd) / 128'd100);
        e.lt   = 64'(((128'd100 - d) * f + rnd) / 128'd100);
        return e;
    endfunction

    function automatic logic [47:0] rand48();
        return 48'({$urandom, $urandom});
    endfunction

    // Monitor: every valid pulse must match the oldest queued expectation
    always @(negedge sys_clk) begin
        if (!sys_rst && valid) begin
            vcount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("freq",      64'(freq),      64'(mon_e.freq));
                checkOutput("duty",      64'(duty),      64'(mon_e.duty));
                checkOutput("high_time", high_time,      mon_e.ht);
                checkOutput("low_time",  low_time,       mon_e.lt);
                checkOutput("err_div0",  64'(err_div0),  64'(mon_e.err));
                checkOutput("busy_at_valid", 64'(busy),  64'd0);
                checkOutput("latency",   64'(cyc),       64'(mon_e.cyc));
            end
        end
    end

    // Issue one calc request, queue its expectation, then scramble the counters
    task automatic applyStimulus(input logic [47:0] t, input logic [47:0] s,
                                 input logic [47:0] h, input logic [47:0] l,
                                 output int k);
        exp_t e;
        @(posedge sys_clk);
        #1;
        cnt_clk_test  = t;
        cnt_clk_stand = s;
        cnt_high      = h;
        cnt_low       = l;
        calc_start    = 1'b1;
        k             = cyc;
        e             = model(t, s, h, l);
        e.cyc         = k + LATENCY;
        sb.push_back(e);
        @(negedge sys_clk);
        checkOutput("overrun_on_accept", 64'(overrun), 64'd0);
        @(posedge sys_clk);
        #1;
        calc_start    = 1'b0;
        cnt_clk_test  = rand48();
        cnt_clk_stand = rand48();
        cnt_high      = rand48();
        cnt_low       = rand48();
        @(negedge sys_clk);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2 * LATENCY) begin
            @(posedge sys_clk);
            n++;
        end
        checkOutput("completion_pending", 64'(sb.size()), 64'd0);
        sb.delete();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic runOne(input logic [47:0] t, input logic [47:0] s,
                          input logic [47:0] h, input logic [47:0] l);
        int k;
        applyStimulus(t, s, h, l, k);
        waitIdle();
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Main sequence
    initial begin
        int          k, v0, mode;
        logic [47:0] t, s, h, l;
        calc_start    = 1'b0;
        cnt_clk_test  = '0;
        cnt_clk_stand = '0;
        cnt_high      = '0;
        cnt_low       = '0;
        sys_rst       = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checkOutput("reset_busy",      64'(busy),      64'd0);
        checkOutput("reset_valid",     64'(valid),     64'd0);
        checkOutput("reset_overrun",   64'(overrun),   64'd0);
        checkOutput("reset_err_div0",  64'(err_div0),  64'd0);
        checkOutput("reset_freq",      64'(freq),      64'd0);
        checkOutput("reset_duty",      64'(duty),      64'd0);
        checkOutput("reset_high_time", high_time,      64'd0);
        checkOutput("reset_low_time",  low_time,       64'd0);

        $display("[TB] directed cases");
        runOne(48'd1000, 48'd100_000, 48'd25_000, 48'd75_000);
        runOne(48'd2, 48'd3, 48'd1, 48'd2);
        runOne(48'd500, 48'd0, 48'd0, 48'd0);
        runOne(48'h0100_0000_0000, 48'd1, 48'd3, 48'd1);
        runOne(48'd12345, 48'd54321, 48'd1, 48'd0);

        $display("[TB] randomized cases");
        for (int i = 0; i < 12; i++) begin
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    t = 48'($urandom_range(1, 1_000_000));
                    s = 48'($urandom_range(1, 10_000_000));
                    h = 48'($urandom_range(0, 1_000_000));
                    l = 48'($urandom_range(0, 1_000_000));
                end
                1: begin
                    t = rand48();
                    s = rand48();
                    h = rand48() >> 1;
                    l = rand48() >> 1;
                end
                2: begin
                    t = 48'($urandom_range(0, 100_000));
                    s = 48'd0;
                    h = 48'($urandom_range(0, 3));
                    l = 48'($urandom_range(0, 3));
                end
                default: begin
                    t = 48'($urandom_range(1, 50_000));
                    s = 48'($urandom_range(1, 200_000));
                    h = ($urandom_range(0, 1) == 0) ? 48'd0 : 48'($urandom_range(1, 9999));
                    l = (h == 48'd0) ? 48'($urandom_range(1, 9999)) : 48'd0;
                end
            endcase
            runOne(t, s, h, l);
        end

        $display("[TB] overrun while busy and in DONE");
        applyStimulus(48'd5000, 48'd100_000, 48'd30_000, 48'd70_000, k);
        v0 = vcount;
        waitUntil(k + 10);
        cnt_clk_test = 48'd7;
        calc_start   = 1'b1;
        @(negedge sys_clk);
        checkOutput("overrun_mid_op", 64'(overrun), 64'd1);
        @(posedge sys_clk);
        #1;
        calc_start = 1'b0;
        waitUntil(k + LATENCY);
        calc_start = 1'b1;
        @(negedge sys_clk);
        checkOutput("overrun_at_done", 64'(overrun), 64'd1);
        checkOutput("valid_at_done",   64'(valid),   64'd1);
        @(posedge sys_clk);
        #1;
        calc_start = 1'b0;
        repeat (LATENCY + 20) @(posedge sys_clk);
        checkOutput("single_valid", 64'(vcount - v0), 64'd1);
        checkOutput("overrun_queue_empty", 64'(sb.size()), 64'd0);
        sb.delete();

        $display("[TB] reset during an operation");
        applyStimulus(48'd777, 48'd1000, 48'd10, 48'd90, k);
        waitUntil(k + 100);
        sys_rst = 1'b1;
        sb.delete();
        @(negedge sys_clk);
        checkOutput("midrst_busy",      64'(busy),     64'd0);
        checkOutput("midrst_valid",     64'(valid),    64'd0);
        checkOutput("midrst_freq",      64'(freq),     64'd0);
        checkOutput("midrst_duty",      64'(duty),     64'd0);
        checkOutput("midrst_high_time", high_time,     64'd0);
        checkOutput("midrst_low_time",  low_time,      64'd0);
        checkOutput("midrst_err_div0",  64'(err_div0), 64'd0);
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        v0 = vcount;
        repeat (LATENCY + 20) @(posedge sys_clk);
        checkOutput("no_valid_after_reset", 64'(vcount - v0), 64'd0);
        runOne(48'd1000, 48'd100_000, 48'd25_000, 48'd75_000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
